// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART receive types, frame constants and baud-divider helper
//  Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync2
//  Purpose  : Two-flop synchroniser with a configurable reset level
//  Revision : 1.0
// ============================================================================
module uart_sync2 #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : UART receive controller issuing mid-bit ticks to a SIPO stage
//             and validating the captured byte, parity and stop bit
//  Revision : 1.0
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic       rxd_sync,
    output logic       tick,
    input  logic [7:0] sipo_data,
    input  logic       sipo_parity,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       STOP_IDX  = 4'(FRAME_BITS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_baud_nxt;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_nxt;
    logic             r_stop_bit;
    logic             w_stop_nxt;
    logic             w_tick;
    logic             w_check;
    logic             w_rxd_sync;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_parity_err;
    logic             r_frame_err;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk_50M),
        .rst_n (reset_n),
        .i_d   (uart_rxd),
        .o_q   (w_rxd_sync)
    );

    // tick is combinational so the SIPO shifts on the same edge the FSM
    // advances; CHECK therefore sees the complete frame in the SIPO.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_stop_nxt  = r_stop_bit;
        w_tick      = 1'b0;
        w_check     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!w_rxd_sync) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_baud_cnt == HALF_LAST) begin
                    w_baud_nxt = '0;
                    if (!w_rxd_sync) begin
                        w_tick      = 1'b1;
                        w_bit_nxt   = 4'd1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_baud_cnt == DIV_LAST) begin
                    w_tick     = 1'b1;
                    w_baud_nxt = '0;
                    if (r_bit_cnt == STOP_IDX) begin
                        w_stop_nxt  = w_rxd_sync;
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_ONE;
                end
            end
            ST_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = r_stop_bit ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (w_rxd_sync) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_stop_bit   <= 1'b1;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_stop_bit <= w_stop_nxt;
            r_rx_valid <= w_check;
            if (w_check) begin
                r_rx_data    <= sipo_data;
                r_parity_err <= ((^{sipo_data, sipo_parity}) != PARITY_ODD);
                r_frame_err  <= !r_stop_bit;
            end
        end
    end

    assign rxd_sync   = w_rxd_sync;
    assign tick       = w_tick;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Directed bench for uart_rx_ctrl with a behavioural SIPO stage
//  Revision : 1.0
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int HALF     = DIV / 2;

    logic       clk_50M = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rxd = 1'b1;

    logic       rxd_sync, tick, rx_valid, parity_err, frame_err, busy;
    logic [7:0] rx_data;
    logic       rxd_sync_b, tick_b, rx_valid_b, parity_err_b, frame_err_b, busy_b;
    logic [7:0] rx_data_b;
    logic [10:0] sr_a = '1;
    logic [10:0] sr_b = '1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int valid_cnt_b = 0;
    int overlap = 0;
    int tick_q[$];
    logic [7:0] data_q[$];

    always #5 clk_50M = ~clk_50M;

    uart_rx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_ODD(1'b0)) dut (
        .clk_50M(clk_50M), .reset_n(reset_n), .uart_rxd(uart_rxd),
        .rxd_sync(rxd_sync), .tick(tick),
        .sipo_data(sr_a[8:1]), .sipo_parity(sr_a[9]),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    uart_rx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_ODD(1'b1)) dut_odd (
        .clk_50M(clk_50M), .reset_n(reset_n), .uart_rxd(uart_rxd),
        .rxd_sync(rxd_sync_b), .tick(tick_b),
        .sipo_data(sr_b[8:1]), .sipo_parity(sr_b[9]),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b), .busy(busy_b)
    );

    // Behavioural SIPO: after 11 ticks [0]=start, [8:1]=D7..D0, [9]=parity, [10]=stop
    always @(posedge clk_50M) begin
        cyc <= cyc + 1;
        if (tick)   sr_a <= {rxd_sync, sr_a[10:1]};
        if (tick_b) sr_b <= {rxd_sync_b, sr_b[10:1]};
    end

    always @(negedge clk_50M) begin
        if (tick) tick_q.push_back(cyc);
        if (rx_valid) begin
            valid_cnt++;
            data_q.push_back(rx_data);
        end
        if (rx_valid_b) valid_cnt_b++;
        if (tick && rx_valid) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        wait_cyc(DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    initial begin
        int tb0, vb, vbb, dq0, bad, start_cyc;

        // Reset state
        wait_cyc(3);
        chk("rst_rxd_sync", rxd_sync, 1);
        chk("rst_tick", tick, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        wait_cyc(5);

        // 1: clean frame 0xA5, even parity bit 0
        tb0 = tick_q.size(); vb = valid_cnt; dq0 = data_q.size();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cyc(5);
        chk("t1_ticks", tick_q.size() - tb0, 11);
        bad = 0;
        if (tick_q.size() - tb0 >= 11) begin
            for (int i = 1; i < 11; i++)
                if (tick_q[tb0+i] - tick_q[tb0+i-1] != DIV) bad++;
            chk("t1_first_tick", tick_q[tb0] - start_cyc, HALF + 2);
        end else begin
            bad = 99;
        end
        chk("t1_spacing", bad, 0);
        chk("t1_valid_cnt", valid_cnt - vb, 1);
        chk("t1_rx_data", rx_data, 8'hA5);
        chk("t1_parity_err", parity_err, 0);
        chk("t1_frame_err", frame_err, 0);
        chk("t1_busy", busy, 0);

        // 2: 0x01 with parity 0 -> even mode error, odd mode clean
        vb = valid_cnt; vbb = valid_cnt_b;
        send_frame(8'h01, 1'b0, 1'b1);
        wait_cyc(5);
        chk("t2_valid_cnt", valid_cnt - vb, 1);
        chk("t2_valid_cnt_odd", valid_cnt_b - vbb, 1);
        chk("t2_rx_data", rx_data, 8'h01);
        chk("t2_parity_err_even", parity_err, 1);
        chk("t2_parity_err_odd", parity_err_b, 0);
        chk("t2_frame_err", frame_err, 0);
        chk("t2_rx_data_odd", rx_data_b, 8'h01);

        // 3: short low glitch, rejected at the start-bit midpoint
        tb0 = tick_q.size(); vb = valid_cnt;
        uart_rxd = 1'b0;
        wait_cyc(4);
        chk("t3_busy_in_start", busy, 1);
        uart_rxd = 1'b1;
        wait_cyc(30);
        chk("t3_ticks", tick_q.size() - tb0, 0);
        chk("t3_valid_cnt", valid_cnt - vb, 0);
        chk("t3_busy", busy, 0);

        // 4: 0x3C with stop bit 0, line then held low
        tb0 = tick_q.size(); vb = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cyc(200);
        chk("t4_valid_cnt", valid_cnt - vb, 1);
        chk("t4_rx_data", rx_data, 8'h3C);
        chk("t4_frame_err", frame_err, 1);
        chk("t4_parity_err", parity_err, 0);
        chk("t4_busy_break", busy, 1);
        uart_rxd = 1'b1;
        wait_cyc(10);
        chk("t4_busy_released", busy, 0);
        chk("t4_ticks", tick_q.size() - tb0, 11);

        // 5: reset during D5 of 0x55, then a clean 0x5A
        vb = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        uart_rxd = 1'b0;
        wait_cyc(HALF);
        chk("t5_busy_before_rst", busy, 1);
        reset_n = 1'b0;
        wait_cyc(2);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_tick", tick, 0);
        chk("t5_rst_rx_data", rx_data, 8'h00);
        chk("t5_rst_frame_err", frame_err, 0);
        chk("t5_rst_rxd_sync", rxd_sync, 1);
        uart_rxd = 1'b1;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(20);
        chk("t5_no_valid", valid_cnt - vb, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cyc(5);
        chk("t5_valid_cnt", valid_cnt - vb, 1);
        chk("t5_rx_data", rx_data, 8'h5A);
        chk("t5_parity_err", parity_err, 0);
        chk("t5_frame_err", frame_err, 0);

        // 6: back-to-back 0x12 (parity 0), 0x34 (parity 1)
        tb0 = tick_q.size(); vb = valid_cnt; dq0 = data_q.size();
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        wait_cyc(5);
        chk("t6_valid_cnt", valid_cnt - vb, 2);
        chk("t6_ticks", tick_q.size() - tb0, 22);
        chk("t6_first_byte", (data_q.size() > dq0) ? 32'(data_q[dq0]) : 32'hFFFF, 8'h12);
        chk("t6_second_byte", (data_q.size() > dq0 + 1) ? 32'(data_q[dq0+1]) : 32'hFFFF, 8'h34);
        chk("t6_parity_err", parity_err, 0);
        chk("t6_frame_err", frame_err, 0);

        chk("tick_valid_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
